// File: rtl/wifi_tx_puncture_sched_if.sv
// Handshake bundle between the puncture scheduler, its buffer FIFO and the
// downstream bit consumer. The slave modport is the scheduler's view.
interface wifi_tx_puncture_sched_if #(
  parameter int unsigned CNT_W = 12
);
  // Control and FIFO/downstream status into the scheduler
  logic             start;
  logic             abort;
  logic [1:0]       rate;
  logic [CNT_W-1:0] n_bits;
  logic             fifo_valid;
  logic             fifo_finished;
  logic             down_ready;

  // Scheduler outputs
  logic             fifo_re;
  logic             keep;
  logic             out_valid;
  logic             sym_end;
  logic             busy;
  logic             done;
  logic             short_sym;
  logic             rate_err;

  modport slave (
    input  start, abort, rate, n_bits, fifo_valid, fifo_finished, down_ready,
    output fifo_re, keep, out_valid, sym_end, busy, done, short_sym, rate_err
  );

  modport master (
    output start, abort, rate, n_bits, fifo_valid, fifo_finished, down_ready,
    input  fifo_re, keep, out_valid, sym_end, busy, done, short_sym, rate_err
  );
endinterface

// File: rtl/wifi_tx_puncture_sched.sv
// 802.11a-style transmit puncture scheduler. Reads n_bits mother-code bits
// from a 1-cycle-latency buffer FIFO, marks each returned beat keep/drop
// according to the latched code rate, and counts kept bits into OFDM symbols
// of N_CBPS bits, flagging symbol boundaries and a partial final symbol.
module wifi_tx_puncture_sched #(
  parameter int unsigned N_CBPS = 48,
  parameter int unsigned CNT_W  = 12
) (
  input logic                     clk,
  input logic                     reset,  // asynchronous, active low
  wifi_tx_puncture_sched_if.slave bus
);

  localparam int unsigned SymW = (N_CBPS > 1) ? $clog2(N_CBPS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e           state_q, state_d;
  logic [1:0]       rate_q, rate_d;
  logic [CNT_W-1:0] n_bits_q, n_bits_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [2:0]       pidx_q, pidx_d;
  // Kept-bit count modulo N_CBPS; only its position inside the symbol matters.
  logic [SymW-1:0]  sym_cnt_q, sym_cnt_d;
  logic             rate_err_q, rate_err_d;

  logic             beat_live;
  logic             pat_bit;
  logic [2:0]       period;
  logic             sym_wrap;
  logic             rd_en;
  logic [CNT_W-1:0] rd_next;

  // Puncture pattern lookup for the latched rate
  always_comb begin
    pat_bit = 1'b1;
    period  = 3'd1;
    case (rate_q)
      2'b01: begin
        period  = 3'd4;
        pat_bit = (pidx_q != 3'd3);
      end
      2'b10: begin
        // A1 B1 A2 B2 A3 B3 with B2 and A3 stolen
        period  = 3'd6;
        pat_bit = !((pidx_q == 3'd3) || (pidx_q == 3'd4));
      end
      default: ;
    endcase
  end

  // Read enable, beat qualification and all block outputs
  always_comb begin
    rd_en     = (state_q == StRun) && bus.down_ready && (rd_cnt_q < n_bits_q) && !bus.abort;
    rd_next   = rd_cnt_q + {{(CNT_W-1){1'b0}}, rd_en};
    // Only beats belonging to the active frame count; a beat landing in IDLE is ignored.
    beat_live = bus.fifo_valid && ((state_q == StRun) || (state_q == StDrain));
    sym_wrap  = (sym_cnt_q == SymW'(N_CBPS - 1));

    bus.fifo_re   = rd_en;
    bus.keep      = beat_live && pat_bit;
    bus.out_valid = beat_live && pat_bit;
    bus.sym_end   = beat_live && pat_bit && sym_wrap;
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StFin);
    bus.short_sym = (state_q == StFin) && (sym_cnt_q != '0);
    bus.rate_err  = rate_err_q;
  end

  // Next-state: FSM, counters and pattern index
  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    n_bits_d   = n_bits_q;
    rd_cnt_d   = rd_cnt_q;
    pidx_d     = pidx_q;
    sym_cnt_d  = sym_cnt_q;
    rate_err_d = 1'b0;

    // Pattern and kept counters advance only on live beats, so stalls hold them.
    if (beat_live) begin
      pidx_d = (pidx_q == period - 3'd1) ? 3'd0 : pidx_q + 3'd1;
      if (pat_bit) begin
        sym_cnt_d = sym_wrap ? '0 : sym_cnt_q + SymW'(1);
      end
    end

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.rate == 2'b11) begin
            rate_err_d = 1'b1;
          end else begin
            rate_d    = bus.rate;
            n_bits_d  = bus.n_bits;
            rd_cnt_d  = '0;
            pidx_d    = '0;
            sym_cnt_d = '0;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        rd_cnt_d = rd_next;
        // Covers the last read, an exhausted FIFO, and n_bits == 0 in one test.
        if ((rd_next == n_bits_q) || bus.fifo_finished) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (bus.abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      rd_cnt_d  = '0;
      pidx_d    = '0;
      sym_cnt_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rate_q     <= 2'b00;
      n_bits_q   <= '0;
      rd_cnt_q   <= '0;
      pidx_q     <= '0;
      sym_cnt_q  <= '0;
      rate_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      n_bits_q   <= n_bits_d;
      rd_cnt_q   <= rd_cnt_d;
      pidx_q     <= pidx_d;
      sym_cnt_q  <= sym_cnt_d;
      rate_err_q <= rate_err_d;
    end
  end

endmodule

// File: tb/tb_wifi_tx_puncture_sched.sv
// Scoreboard bench for wifi_tx_puncture_sched: the stimulus task pushes the
// expected keep/sym_end per FIFO beat and the expected short_sym per frame;
// an independent monitor pops and compares whenever the DUT presents them.
module tb_wifi_tx_puncture_sched;

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned N_CBPS = 48;

  typedef struct packed {
    logic keep;
    logic sym;
  } beat_t;

  logic clk;
  logic rst_n;

  wifi_tx_puncture_sched_if #(.CNT_W(CNT_W)) bus ();

  wifi_tx_puncture_sched #(
    .N_CBPS(N_CBPS),
    .CNT_W (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer FIFO model: data returns one cycle after the read enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.fifo_valid <= 1'b0;
    else        bus.fifo_valid <= bus.fifo_re;
  end

  int    n_tests = 0;
  int    n_fail  = 0;
  int    kept_seen;
  bit    mon_en;
  beat_t q_beat[$];
  bit    q_done[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Hand-written puncture tables (bit i = pattern position i)
  function automatic bit pat(input logic [1:0] r, input int i);
    logic [3:0] p23;
    logic [5:0] p34;
    p23 = 4'b0111;
    p34 = 6'b100111;
    case (r)
      2'b01:   return p23[i % 4];
      2'b10:   return p34[i % 6];
      default: return 1'b1;
    endcase
  endfunction

  // Monitor: pops an expectation for every beat and every done pulse
  always @(negedge clk) begin
    beat_t e;
    if (mon_en && rst_n) begin
      if (bus.fifo_valid) begin
        if (q_beat.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          e = q_beat.pop_front();
          chk("keep", bus.keep, e.keep);
          chk("out_valid", bus.out_valid, e.keep);
          chk("sym_end", bus.sym_end, e.sym);
          if (bus.out_valid) kept_seen++;
        end
      end else begin
        chk("idle_beat_outs", {bus.keep, bus.out_valid, bus.sym_end}, 0);
      end
      if (bus.done) begin
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else                    chk("short_sym", bus.short_sym, q_done.pop_front());
      end
    end
  end

  // Runs one frame; cycle 0 is the start cycle. Stall cycles st_lo..st_hi drop
  // down_ready, fin_cyc (0 = never) raises fifo_finished, abort_cyc (0 = never)
  // pulses abort. exp_kept/exp_short/exp_done are the hand-computed results.
  task automatic run_frame(input string nm, input logic [1:0] r, input int n,
                           input int st_lo, input int st_hi, input int fin_cyc,
                           input int abort_cyc, input int exp_kept, input bit exp_short,
                           input bit exp_done);
    int  rd, k, beat, end_cyc;
    bit  in_run, aborted, exp_re, exp_busy, ended, pb;
    rd = 0; k = 0; beat = 0; end_cyc = 0; aborted = 0; ended = 0;
    kept_seen = 0;
    if (exp_done) q_done.push_back(exp_short);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.rate   = r;
    bus.n_bits = CNT_W'(n);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      bus.start         = 1'b0;
      bus.down_ready    = !(cyc >= st_lo && cyc <= st_hi);
      bus.abort         = (cyc == abort_cyc);
      bus.fifo_finished = (fin_cyc != 0) && (cyc >= fin_cyc);
      @(negedge clk);
      in_run = (end_cyc == 0);
      exp_re = in_run && bus.down_ready && (rd < n) && !bus.abort;
      chk({nm, "_fifo_re"}, bus.fifo_re, exp_re);
      if (exp_re) begin
        pb = pat(r, beat);
        beat++;
        rd++;
        if (pb) k++;
        q_beat.push_back('{keep: pb, sym: pb && (k % N_CBPS == 0)});
      end
      exp_busy = in_run || (!aborted && cyc <= end_cyc + 2);
      chk({nm, "_busy"}, bus.busy, exp_busy);
      chk({nm, "_done"}, bus.done, !in_run && !aborted && (cyc == end_cyc + 2));
      if (in_run && (bus.abort || rd == n || bus.fifo_finished)) begin
        end_cyc = cyc;
        aborted = bus.abort;
      end
      if (end_cyc != 0 && cyc >= end_cyc + 3) begin
        ended = 1;
        break;
      end
    end
    bus.abort         = 1'b0;
    bus.fifo_finished = 1'b0;
    bus.down_ready    = 1'b1;
    if (!ended) chk({nm, "_timeout"}, 1, 0);
    chk({nm, "_kept_total"}, kept_seen, exp_kept);
    chk({nm, "_beats_left"}, q_beat.size(), 0);
    chk({nm, "_done_left"}, q_done.size(), 0);
    q_beat.delete();
    q_done.delete();
  endtask

  function automatic logic [7:0] all_outs();
    return {bus.fifo_re, bus.keep, bus.out_valid, bus.sym_end,
            bus.busy, bus.done, bus.short_sym, bus.rate_err};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    mon_en            = 1'b0;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.rate          = 2'b00;
    bus.n_bits        = '0;
    bus.fifo_finished = 1'b0;
    bus.down_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1 chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_outs", all_outs(), 0);
    end
    mon_en = 1'b1;

    // Rate 3/4, 12 beats: 8 kept, partial symbol, done at cycle 14
    run_frame("r34_n12", 2'b10, 12, 0, 0, 0, 0, 8, 1'b1, 1'b1);
    // Rate 1/2, two full symbols: sym_end on 48th and 96th kept bits
    run_frame("r12_n96", 2'b00, 96, 0, 0, 0, 0, 96, 1'b0, 1'b1);
    // Rate 2/3 with a three-cycle downstream stall
    run_frame("r23_stall", 2'b01, 8, 3, 5, 0, 0, 6, 1'b1, 1'b1);

    // Illegal rate: one rate_err pulse, never busy, no reads
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.rate   = 2'b11;
    bus.n_bits = CNT_W'(12);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rate_err_pulse", {bus.rate_err, bus.busy, bus.fifo_re}, 3'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rate_err_after", {bus.rate_err, bus.busy, bus.fifo_re}, 3'b000);
    end

    // Abort on the 5th read, then a clean rerun of the same frame
    run_frame("abort", 2'b00, 20, 0, 0, 0, 5, 4, 1'b0, 1'b0);
    run_frame("rerun", 2'b00, 20, 0, 0, 0, 0, 20, 1'b1, 1'b1);
    // Zero-length frame: one RUN cycle, no reads, full (empty) symbol
    run_frame("n0", 2'b01, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    // FIFO runs dry at cycle 5 coinciding with a read
    run_frame("fifo_fin", 2'b00, 10, 0, 0, 5, 0, 5, 1'b1, 1'b1);

    // Reset asserted mid-RUN with a beat in flight
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.rate   = 2'b00;
    bus.n_bits = CNT_W'(40);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_running", {bus.busy, bus.fifo_re}, 2'b11);
    rst_n = 1'b0;
    #1 chk("mid_reset_outs", all_outs(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_reset_idle", all_outs(), 0);
    end
    mon_en = 1'b1;
    run_frame("r34_after_rst", 2'b10, 12, 0, 0, 0, 0, 8, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wifi_tx_puncture_sched.md
WIFI_TX_PUNCTURE_SCHED -- requirements
Module: wifi_tx_puncture_sched

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_CBPS, 48, coded bits per OFDM symbol after puncturing.
- CNT_W, 12, width of the bit counters.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle frame start request.
- abort, input, 1, synchronous frame cancel.
- rate, input, 2, 00 = rate 1/2, 01 = rate 2/3, 10 = rate 3/4, 11 = illegal.
- n_bits, input, CNT_W, number of mother-code bits to read from the buffer FIFO.
- fifo_valid, input, 1, buffer FIFO data-valid, one cycle after fifo_re.
- fifo_finished, input, 1, buffer FIFO has no more data.
- down_ready, input, 1, downstream can accept a bit.
- fifo_re, output, 1, FIFO read enable.
- keep, output, 1, puncture-pattern bit aligned with fifo_valid.
- out_valid, output, 1, equals fifo_valid AND keep; marks a transmitted bit.
- sym_end, output, 1, one-cycle pulse on the N_CBPS-th kept bit of each symbol.
- busy, output, 1, high outside IDLE.
- done, output, 1, one-cycle frame-complete pulse.
- short_sym, output, 1, high with done when the final symbol is partial.
- rate_err, output, 1, one-cycle pulse when start arrives with rate = 11.

Function
REQ-003 The FSM SHALL have four states: IDLE, RUN, DRAIN, FIN.
REQ-004 In IDLE, start with a legal rate SHALL do three things: latch rate and n_bits, clear all counters, and move to RUN on the next cycle.
REQ-005 In IDLE, start with rate = 11 SHALL pulse rate_err for one cycle and leave the FSM in IDLE.
REQ-006 start SHALL be ignored whenever busy = 1.
REQ-007 In RUN, fifo_re SHALL be the combinational value (state == RUN) AND down_ready AND (rd_cnt < n_bits).
- rd_cnt increments on every cycle with fifo_re = 1.
REQ-008 RUN SHALL go to DRAIN on the cycle after any of these:
- rd_cnt reaches n_bits;
- fifo_finished = 1;
- a latched n_bits of 0 (RUN then lasts one cycle and issues no reads).
REQ-009 DRAIN SHALL last exactly one cycle, so the last in-flight fifo_valid beat is absorbed, and then go to FIN.
REQ-010 FIN SHALL last one cycle with done = 1 and then go to IDLE.
- short_sym = 1 in FIN iff the kept-bit counter is nonzero modulo N_CBPS.
REQ-011 Puncture patterns SHALL be indexed by a pattern counter pidx that advances once per fifo_valid beat and wraps at the period:
- rate 1/2: pattern 1, period 1.
- rate 2/3: pattern 1,1,1,0, period 4.
- rate 3/4: pattern 1,1,1,0,0,1, period 6 (order A1 B1 A2 B2 A3 B3, keeping A1 B1 A2 B3).
REQ-012 keep SHALL be the pattern bit at pidx for the current fifo_valid beat.
- keep = 0 when fifo_valid = 0.
- pidx does not advance when fifo_valid = 0.
REQ-013 The kept-bit counter SHALL increment on each out_valid.
- sym_end pulses on the same cycle as the out_valid that brings the count to a multiple of N_CBPS.
- The symbol counter wraps to 0 after N_CBPS and does not saturate.
REQ-014 down_ready low SHALL stall reads on that same cycle.
- At most one in-flight beat (issued on the previous cycle) may still appear.
- pidx and all counters hold during the stall.
REQ-015 abort in any non-IDLE state SHALL return the FSM to IDLE on the next edge.
- fifo_re goes low combinationally in the abort cycle.
- Counters and pidx clear.
- No done pulse is issued.
REQ-016 If fifo_finished and the final read coincide, the FSM SHALL take a single transition to DRAIN.

Reset
REQ-017 reset low SHALL asynchronously force the following, regardless of current state:
- state to IDLE;
- rd_cnt, pidx, the kept counter and the symbol counter to 0;
- the latched rate to 00;
- fifo_re, keep, out_valid, sym_end, busy, done, short_sym and rate_err to 0.
REQ-018 After reset is released, no output SHALL change until the first start.

Verification
REQ-019 Rate 3/4, n_bits = 12, down_ready = 1, FIFO with 1-cycle latency:
- start at cycle 0, so fifo_re is high for cycles 1-12;
- keep sequence is 1,1,1,0,0,1,1,1,1,0,0,1 and out_valid is high 8 times;
- DRAIN at cycle 13, done at cycle 14, short_sym = 1.
REQ-020 Rate 1/2, n_bits = 96, N_CBPS = 48:
- sym_end pulses on the 48th and 96th kept bits;
- done follows with short_sym = 0.
REQ-021 Rate 2/3, n_bits = 8, down_ready low for cycles 3-5:
- fifo_re is low during cycles 3-5 and reads resume afterwards;
- keep sequence is 1,1,1,0,1,1,1,0 with no pattern slip;
- 6 kept bits in total.
REQ-022 start with rate = 11: rate_err pulses for one cycle, busy stays 0, fifo_re never asserts.
REQ-023 abort on the 5th read of a rate 1/2, n_bits = 20 frame:
- busy = 0 on the next cycle;
- no done pulse;
- a following start runs the full 20 reads from pidx = 0.
REQ-024 reset asserted mid-RUN: all outputs are 0 immediately, and the FSM is in IDLE once reset is released.
